// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the UART byte streams and the Sobel filter: header parse, ACK/NAK, pixel and result routing.
// Optional RX idle abort is compiled in with `define SOBEL_FRAME_TIMEOUT_EN.
module sobel_frame_ctrl #(
    parameter int          MAX_WIDTH_P      = 640,
    parameter int          MAX_HEIGHT_P     = 480,
    parameter logic [7:0]  SYNC_BYTE_P      = 8'hA5,
    parameter int          TIMEOUT_CYCLES_P = 25000000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        f_valid_o,
    output logic [7:0]  f_data_o,
    output logic        f_last_o,
    input  logic        f_ready_i,
    output logic [15:0] f_width_o,
    output logic        f_start_o,
    input  logic        fo_valid_i,
    input  logic [7:0]  fo_data_i,
    output logic        fo_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int         CNT_W    = $clog2(MAX_WIDTH_P * MAX_HEIGHT_P + 1);
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;
    localparam logic [15:0] MAX_W16 = 16'(MAX_WIDTH_P);
    localparam logic [15:0] MAX_H16 = 16'(MAX_HEIGHT_P);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_STREAM
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         hdr_idx_q, hdr_idx_d;
    logic [15:0]        w_q, w_d;
    logic [15:0]        h_q, h_d;
    logic [15:0]        width_q, width_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               err_q, err_d;
    logic               check_first_q, check_first_d;

    logic               in_stream;
    logic               in_check;
    logic               in_done;
    logic               out_done;
    logic               hdr_ok;
    logic [CNT_W-1:0]   area;
    logic               rx_ready_int;
    logic               rx_hs;
    logic               f_hs;
    logic               tx_hs;
    logic               f_start_c;
    logic               timeout_hit;

    assign in_stream = (state_q == S_STREAM);
    assign in_check  = (state_q == S_CHECK);
    assign in_done   = (in_cnt_q == total_q);
    assign out_done  = (out_cnt_q == total_q);

    assign hdr_ok = (w_q != 16'd0) && (w_q <= MAX_W16) && (h_q != 16'd0) && (h_q <= MAX_H16);
    // Only consumed when hdr_ok, so narrowing the operands cannot lose a legal product.
    assign area   = CNT_W'(w_q) * CNT_W'(h_q);

    assign rx_ready_int = (state_q == S_IDLE) || (state_q == S_HDR) ||
                          (in_stream && f_ready_i && !in_done);
    // IDLE advertises ready, so gate with the reset pin to keep outputs low during reset.
    assign rx_ready_o   = rx_ready_int && reset_n_i;
    assign rx_hs        = rx_valid_i && rx_ready_int;

    assign f_valid_o  = in_stream && rx_valid_i && !in_done;
    assign f_data_o   = in_stream ? rx_data_i : 8'h00;
    assign f_last_o   = in_stream && (in_cnt_q == total_q - CNT_W'(1));
    assign f_hs       = f_valid_o && f_ready_i;

    assign fo_ready_o = in_stream && tx_ready_i && !out_done;
    assign tx_valid_o = in_check || (in_stream && fo_valid_i && !out_done);
    assign tx_data_o  = in_check  ? (hdr_ok ? ACK_BYTE : NAK_BYTE) :
                        in_stream ? fo_data_i : 8'h00;
    assign tx_hs      = in_stream && fo_valid_i && fo_ready_o;

    assign f_width_o  = width_q;
    assign f_start_o  = f_start_c;
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;

`ifdef SOBEL_FRAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES_P + 1);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            to_armed;

    assign to_armed    = (state_q == S_HDR) || (in_stream && !in_done);
    assign timeout_hit = to_armed && !rx_hs && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES_P - 1));

    always_comb begin
        idle_cnt_d = '0;
        if (to_armed && !rx_hs) begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        w_d           = w_q;
        h_d           = h_q;
        width_d       = width_q;
        total_d       = total_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        err_d         = err_q;
        check_first_d = 1'b0;
        f_start_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE_P)) begin
                    state_d   = S_HDR;
                    hdr_idx_d = 2'd0;
                end
            end

            S_HDR: begin
                // A sync byte here is plain header data; there is no resync.
                if (rx_valid_i) begin
                    case (hdr_idx_q)
                        2'd0:    w_d[7:0]  = rx_data_i;
                        2'd1:    w_d[15:8] = rx_data_i;
                        2'd2:    h_d[7:0]  = rx_data_i;
                        default: h_d[15:8] = rx_data_i;
                    endcase
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        state_d       = S_CHECK;
                        check_first_d = 1'b1;
                    end
                end
            end

            S_CHECK: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                if (check_first_q) begin
                    if (hdr_ok) begin
                        width_d   = w_q;
                        total_d   = area;
                        err_d     = 1'b0;
                        f_start_c = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (tx_ready_i) begin
                    state_d = hdr_ok ? S_STREAM : S_IDLE;
                end
            end

            S_STREAM: begin
                if (f_hs) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                end
                if (tx_hs) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                end
                if ((in_cnt_d == total_q) && (out_cnt_d == total_q)) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Idle abort flushes the filter so a stale partial frame cannot leak into the next one.
        if (timeout_hit) begin
            state_d   = S_IDLE;
            err_d     = 1'b1;
            f_start_c = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            hdr_idx_q     <= 2'd0;
            w_q           <= 16'd0;
            h_q           <= 16'd0;
            width_q       <= 16'd0;
            total_q       <= '0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            err_q         <= 1'b0;
            check_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_idx_q     <= hdr_idx_d;
            w_q           <= w_d;
            h_q           <= h_d;
            width_q       <= width_d;
            total_q       <= total_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            err_q         <= err_d;
            check_first_q <= check_first_d;
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: table of frames plus hand-written reset/garbage/timeout sequences.
// The filter is modelled as an echoing FIFO; build with SOBEL_FRAME_TIMEOUT_EN to add the idle-abort sequence.
module tb_sobel_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        f_valid_o;
    logic [7:0]  f_data_o;
    logic        f_last_o;
    logic        f_ready_i;
    logic [15:0] f_width_o;
    logic        f_start_o;
    logic        fo_valid_i;
    logic [7:0]  fo_data_i;
    logic        fo_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    sobel_frame_ctrl #(
        .MAX_WIDTH_P     (640),
        .MAX_HEIGHT_P    (480),
        .SYNC_BYTE_P     (8'hA5),
        .TIMEOUT_CYCLES_P(100)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .rx_ready_o (rx_ready_o),
        .f_valid_o  (f_valid_o),
        .f_data_o   (f_data_o),
        .f_last_o   (f_last_o),
        .f_ready_i  (f_ready_i),
        .f_width_o  (f_width_o),
        .f_start_o  (f_start_o),
        .fo_valid_i (fo_valid_i),
        .fo_data_i  (fo_data_i),
        .fo_ready_o (fo_ready_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    typedef struct {
        int         w;
        int         h;
        logic [7:0] resp;
        bit         err;
        int         starts;
        bit         tx_tog;
        bit         stall;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    logic [7:0] rx_q[$];
    logic [7:0] filt_q[$];
    logic [7:0] tx_log[$];

    int cyc;
    int errors;
    int checks;
    int start_cnt;
    int last_cnt;
    logic [7:0] last_data;
    int f_hs_cnt;
    int stall_left;
    bit tx_toggle;
    int last_tx_cyc;
    int last_rx_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int k, input int i);
        return 8'(i + 16 * k);
    endfunction

    function automatic logic [39:0] out_vec();
        return {rx_ready_o, f_valid_o, f_data_o, f_last_o, f_width_o, f_start_o,
                fo_ready_o, tx_valid_o, tx_data_o, busy_o, err_o};
    endfunction

    // Called at a falling edge: drive inputs, settle, record the handshakes of the coming rising edge.
    task automatic cycle();
        rx_valid_i = (rx_q.size() > 0);
        rx_data_i  = rx_valid_i ? rx_q[0] : 8'h00;
        f_ready_i  = !((stall_left > 0) && (f_hs_cnt == 2));
        if (!f_ready_i) stall_left--;
        fo_valid_i = (filt_q.size() > 0);
        fo_data_i  = fo_valid_i ? filt_q[0] : 8'h00;
        tx_ready_i = tx_toggle ? cyc[0] : 1'b1;
        #1;
        if (f_start_o) start_cnt++;
        if (fo_valid_i && fo_ready_o) void'(filt_q.pop_front());
        if (f_valid_o && f_ready_i) begin
            f_hs_cnt++;
            filt_q.push_back(f_data_o);
            if (f_last_o) begin
                last_cnt++;
                last_data = f_data_o;
            end
        end
        if (rx_valid_i && rx_ready_o) begin
            void'(rx_q.pop_front());
            last_rx_cyc = cyc;
        end
        if (tx_valid_o && tx_ready_i) begin
            tx_log.push_back(tx_data_o);
            last_tx_cyc = cyc;
        end
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic run_until_idle(input int budget, output int fall, output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        fall = 0;
        for (int t = 0; t < budget && !ok; t++) begin
            cycle();
            if (busy_o) seen = 1'b1;
            else if (seen && rx_q.size() == 0) begin
                ok   = 1'b1;
                fall = cyc;
            end
        end
    endtask

    task automatic clear_tb();
        rx_q.delete();
        filt_q.delete();
        tx_log.delete();
        start_cnt  = 0;
        last_cnt   = 0;
        last_data  = 8'h00;
        f_hs_cnt   = 0;
        stall_left = 0;
        tx_toggle  = 1'b0;
    endtask

    initial begin
        int         n;
        int         bad;
        int         fall_cyc;
        bit         ok;
        logic [15:0] w16;
        logic [15:0] h16;
        vec_t       v;

        vecs[0]  = '{4,   3,   8'h06, 1'b0, 1, 1'b0, 1'b0};
        vecs[1]  = '{0,   3,   8'h15, 1'b1, 0, 1'b0, 1'b0};
        vecs[2]  = '{2,   2,   8'h06, 1'b0, 1, 1'b0, 1'b0};
        vecs[3]  = '{2,   2,   8'h06, 1'b0, 1, 1'b1, 1'b1};
        vecs[4]  = '{641, 1,   8'h15, 1'b1, 0, 1'b0, 1'b0};
        vecs[5]  = '{640, 1,   8'h06, 1'b0, 1, 1'b1, 1'b0};
        vecs[6]  = '{1,   481, 8'h15, 1'b1, 0, 1'b0, 1'b0};
        vecs[7]  = '{1,   480, 8'h06, 1'b0, 1, 1'b0, 1'b1};
        vecs[8]  = '{165, 1,   8'h06, 1'b0, 1, 1'b0, 1'b0};
        vecs[9]  = '{1,   1,   8'h06, 1'b0, 1, 1'b0, 1'b0};
        vecs[10] = '{4,   0,   8'h15, 1'b1, 0, 1'b0, 1'b0};

        errors = 0;
        checks = 0;
        cyc    = 0;
        last_tx_cyc = 0;
        last_rx_cyc = 0;
        clear_tb();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        f_ready_i  = 1'b0;
        fo_valid_i = 1'b0;
        fo_data_i  = 8'h00;
        tx_ready_i = 1'b0;

        // Reset held for 5 cycles
        reset_n_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("reset_outputs", out_vec(), 40'd0);
        reset_n_i = 1'b1;
        #1;
        check("post_reset_rx_ready", rx_ready_o, 1'b1);
        check("post_reset_busy", busy_o, 1'b0);
        check("post_reset_err", err_o, 1'b0);
        check("post_reset_width", f_width_o, 16'd0);
        check("post_reset_tx_valid", tx_valid_o, 1'b0);
        @(negedge clk_i);
        $display("reset: outputs idle, rx_ready=%0b", rx_ready_o);

        // Garbage before sync, then reset after the 2nd pixel
        clear_tb();
        rx_q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h02, 8'h00, 8'h02, 8'h00,
                 8'h10, 8'h11, 8'h12, 8'h13};
        for (int t = 0; t < 200 && f_hs_cnt < 2; t++) cycle();
        check("garbage_pixels_in", f_hs_cnt, 2);
        check("garbage_ack", (tx_log.size() > 0) ? tx_log[0] : 8'hEE, 8'h06);
        check("garbage_start", start_cnt, 1);
        check("garbage_width", f_width_o, 16'd2);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("midreset_outputs", out_vec(), 40'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        clear_tb();
        #1;
        check("midreset_busy", busy_o, 1'b0);
        check("midreset_rx_ready", rx_ready_o, 1'b1);
        @(negedge clk_i);
        $display("garbage+midreset: ack seen, reset to idle");

        // Table of frames
        for (int k = 0; k < NVEC; k++) begin
            v = vecs[k];
            clear_tb();
            tx_toggle  = v.tx_tog;
            stall_left = v.stall ? 3 : 0;
            w16 = 16'(v.w);
            h16 = 16'(v.h);
            rx_q.push_back(8'hA5);
            rx_q.push_back(w16[7:0]);
            rx_q.push_back(w16[15:8]);
            rx_q.push_back(h16[7:0]);
            rx_q.push_back(h16[15:8]);
            n = (v.resp == 8'h06) ? v.w * v.h : 0;
            for (int i = 0; i < n; i++) rx_q.push_back(pix(k, i));

            run_until_idle(5000, fall_cyc, ok);
            check("frame_done", ok, 1'b1);
            check("frame_resp", (tx_log.size() > 0) ? tx_log[0] : 8'hEE, v.resp);
            check("frame_tx_count", tx_log.size(), n + 1);
            bad = 0;
            for (int i = 0; i < n; i++) begin
                if (i + 1 >= tx_log.size() || tx_log[i + 1] !== pix(k, i)) bad++;
            end
            check("frame_payload_bad", bad, 0);
            check("frame_in_count", f_hs_cnt, n);
            check("frame_err", err_o, v.err);
            check("frame_starts", start_cnt, v.starts);
            check("frame_busy_fall", fall_cyc - last_tx_cyc, 1);
            if (v.resp == 8'h06) begin
                check("frame_width", f_width_o, w16);
                check("frame_last_cnt", last_cnt, 1);
                check("frame_last_data", last_data, pix(k, n - 1));
            end
            $display("frame %0d: %0dx%0d resp=%02h tx_bytes=%0d err=%0b starts=%0d",
                     k, v.w, v.h, (tx_log.size() > 0) ? tx_log[0] : 8'hEE,
                     tx_log.size(), err_o, start_cnt);
            repeat (2) cycle();
        end

`ifdef SOBEL_FRAME_TIMEOUT_EN
        // RX stalls after 1 of 4 pixels: abort after 100 idle cycles
        clear_tb();
        rx_q = '{8'hA5, 8'h02, 8'h00, 8'h02, 8'h00, 8'h55};
        run_until_idle(400, fall_cyc, ok);
        check("timeout_done", ok, 1'b1);
        check("timeout_err", err_o, 1'b1);
        check("timeout_starts", start_cnt, 2);
        check("timeout_latency", fall_cyc - last_rx_cyc, 101);
        check("timeout_tx_count", tx_log.size(), 2);
        $display("timeout: err=%0b starts=%0d latency=%0d", err_o, start_cnt, fall_cyc - last_rx_cyc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer between the UART byte streams and the Sobel filter datapath. It parses a host frame header (sync, width, height), configures the filter's line width, and returns ACK or NAK to the host. It then forwards exactly W*H pixel bytes into the filter and routes exactly W*H filtered bytes back to UART TX before accepting the next frame. All streams use valid/ready; a byte transfers on any cycle where both are high.

Parameters:
MAX_WIDTH_P, 640, largest accepted frame width in pixels
MAX_HEIGHT_P, 480, largest accepted frame height in pixels
SYNC_BYTE_P, 8'hA5, frame start marker
TIMEOUT_CYCLES_P, 25000000, RX idle limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  single clock, 25 MHz domain
reset_n_i  in  1  asynchronous active-low reset
rx_valid_i  in  1  UART RX byte valid
rx_data_i  in  8  UART RX byte
rx_ready_o  out  1  UART RX byte accepted
f_valid_o  out  1  pixel to filter valid
f_data_o  out  8  pixel to filter
f_last_o  out  1  final pixel of frame
f_ready_i  in  1  filter accepts pixel
f_width_o  out  16  configured line width, stable while busy_o=1
f_start_o  out  1  one-cycle pulse; filter clears line buffers
fo_valid_i  in  1  filtered byte valid
fo_data_i  in  8  filtered byte
fo_ready_o  out  1  filtered byte accepted
tx_valid_o  out  1  UART TX byte valid
tx_data_o  out  8  UART TX byte
tx_ready_i  in  1  UART TX accepts byte
busy_o  out  1  frame in progress (state != IDLE)
err_o  out  1  sticky error flag; cleared by the next valid header

Behaviour:
- Clock and reset: one clock, clk_i. Reset is reset_n_i, asynchronous and active-low. While reset is asserted, every output is 0 and f_width_o is 16'd0. State resets to IDLE and all counters reset to 0.
- IDLE:
  - rx_ready_o=1.
  - A received byte equal to SYNC_BYTE_P moves to HDR. Any other byte is discarded.
- HDR:
  - rx_ready_o=1. Accepts 4 bytes in order: W_lo, W_hi, H_lo, H_hi.
  - A SYNC byte received here is treated as header data, with no resync.
  - After the 4th byte, moves to CHECK.
- CHECK:
  - rx_ready_o=0.
  - Valid header (1<=W<=MAX_WIDTH_P and 1<=H<=MAX_HEIGHT_P):
    - latches f_width_o=W; pulses f_start_o for 1 cycle; clears err_o;
    - presents tx_data_o=8'h06 (ACK) with tx_valid_o=1;
    - holds until tx_ready_i, then moves to STREAM.
  - Invalid header:
    - presents 8'h15 (NAK) and sets err_o;
    - holds until tx_ready_i, then returns to IDLE.
- STREAM (input side):
  - Combinational pass-through: f_valid_o=rx_valid_i, f_data_o=rx_data_i, rx_ready_o=f_ready_i.
  - in_cnt increments on each filter handshake. f_last_o=1 when in_cnt==W*H-1.
  - After the last input handshake, rx_ready_o=0 and f_valid_o=0 until the frame completes.
- STREAM (output side, concurrent):
  - tx_valid_o=fo_valid_i, tx_data_o=fo_data_i, fo_ready_o=tx_ready_i.
  - out_cnt increments on each TX handshake.
- Completion:
  - When in_cnt==W*H and out_cnt==W*H, return to IDLE on the next cycle.
  - If the final input and final output handshakes occur in the same cycle, both counts are taken and the block still returns to IDLE the next cycle.
  - Extra filter bytes arriving after out_cnt==W*H are not accepted (fo_ready_o=0 outside STREAM).
- Arithmetic:
  - W*H is computed once in CHECK into a register of width clog2(MAX_WIDTH_P*MAX_HEIGHT_P+1).
  - Counters use the same width and never wrap within a legal frame.
- Outside STREAM: fo_ready_o=0 and f_valid_o=0. tx_valid_o is driven only by CHECK (ACK/NAK) or STREAM.
- Reset mid-frame: asserting reset_n_i at any point aborts to IDLE, and all outputs are 0 immediately (asynchronous).

Optional Feature:
- Macro: SOBEL_FRAME_TIMEOUT_EN.
- Defined:
  - In HDR and STREAM, an idle counter reloads on every RX handshake.
  - If TIMEOUT_CYCLES_P cycles pass with no RX handshake while in_cnt<W*H, the block aborts: sets err_o, pulses f_start_o to flush the filter, and goes to IDLE.
  - The counter is held at 0 in other states.
- Not defined: no counter logic is synthesized, and the block waits for input indefinitely.

Test Plan:
- Reset: hold reset_n_i=0 for 5 cycles, release -> all outputs 0, busy_o=0, rx_ready_o=1.
- Valid 4x3 frame: send A5 04 00 03 00, then 12 pixels 0x00..0x0B, with the filter model echoing each pixel -> TX sees 06 then 12 bytes; f_width_o=4; f_start_o pulses once; f_last_o is high only on pixel 0x0B; busy_o falls after the 12th TX byte.
- Invalid width: send A5 00 00 03 00 -> TX emits 15, err_o=1, returns to IDLE with no f_start_o. A following valid 2x2 frame clears err_o and returns 06.
- Backpressure: 2x2 frame with tx_ready_i toggled every other cycle and f_ready_i low for 3 cycles mid-stream -> no byte dropped or duplicated, exact byte order preserved, counts both reach 4.
- Garbage and mid-frame reset: send 00 FF 12 then A5 02 00 02 00 -> the first three bytes are ignored and ACK is sent. Assert reset after the 2nd pixel -> IDLE, and a new frame completes normally.
- With SOBEL_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES_P=100: stop RX after 1 of 4 pixels -> at cycle 100 err_o=1, f_start_o pulses, busy_o=0.
